router_in_fifo: RTL and testbench



---
 rtl/router_in_fifo.sv | 117 +++++++++++
 tb/tb_router_in_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/router_in_fifo.sv
// router_in_fifo: per-port input FIFO of the ring router.
// First-word-fall-through buffer of DEPTH flits; bit 0 of a flit is its
// valid bit, and invalid flits are never stored. Occupancy flags are pure
// decodes of the entry count.
// Optional macro ROUTER_FIFO_ERR_EN adds the sticky ovf/udf flags and the
// saturating drops counter; without it those outputs are tied low.
module router_in_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             read,
  output logic [WIDTH-1:0] dataOut,
  output logic             empty,
  output logic             almost_empty,
  output logic             full,
  output logic             almost_full,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic             udf,
  output logic [7:0]       drops
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             pushOk;
  logic             popOk;

  // A pop needs a stored flit; a push needs a valid flit and either a free
  // slot or a simultaneous pop that frees one.
  assign popOk  = read && (cnt != '0);
  assign pushOk = write && dataIn[0] && ((cnt != FULL_CNT) || popOk);

  // Flit storage is not reset; only the pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem[wp] <= dataIn;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (pushOk) begin
        wp <= wp + 1'b1;
      end
      if (popOk) begin
        rp <= rp + 1'b1;
      end
      case ({pushOk, popOk})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head flit is forced to zero when empty so the valid bit reads 0.
  assign dataOut      = (cnt != '0) ? mem[rp] : '0;
  assign count        = cnt;
  assign empty        = (cnt == '0);
  assign almost_empty = (cnt == (AW + 1)'(1));
  assign full         = (cnt == FULL_CNT);
  assign almost_full  = (cnt == FULL_CNT - 1'b1);

`ifdef ROUTER_FIFO_ERR_EN
  logic       ovfR;
  logic       udfR;
  logic [7:0] dropsR;
  logic       refused;

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A valid flit offered while full with no pop alongside is a refused push.
  assign refused = write && dataIn[0] && (cnt == FULL_CNT) && !popOk;

  // Sticky error flags and the saturating drop counter; cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovfR   <= 1'b0;
      udfR   <= 1'b0;
      dropsR <= '0;
    end else begin
      if (refused) begin
        ovfR   <= 1'b1;
        dropsR <= satInc(dropsR);
      end
      if (read && (cnt == '0)) begin
        udfR <= 1'b1;
      end
    end
  end

  assign ovf   = ovfR;
  assign udf   = udfR;
  assign drops = dropsR;
`else
  assign ovf   = 1'b0;
  assign udf   = 1'b0;
  assign drops = '0;
`endif

endmodule

// File: tb/tb_router_in_fifo.sv
// Directed bench for router_in_fifo: stimulus queues the expected flit of
// every pop it issues; a negedge monitor compares dataOut against the queue
// whenever a pop handshake (read with the FIFO non-empty) is presented.
module tb_router_in_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

`ifdef ROUTER_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             write;
  logic [WIDTH-1:0] dataIn;
  logic             read;
  logic [WIDTH-1:0] dataOut;
  logic             empty;
  logic             almost_empty;
  logic             full;
  logic             almost_full;
  logic [AW:0]      count;
  logic             ovf;
  logic             udf;
  logic [7:0]       drops;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] expQ [$];

  router_in_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .write(write), .dataIn(dataIn), .read(read),
    .dataOut(dataOut), .empty(empty), .almost_empty(almost_empty),
    .full(full), .almost_full(almost_full), .count(count),
    .ovf(ovf), .udf(udf), .drops(drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a pop is presented when read is high and not empty.
  always @(negedge clk) begin
    if (!reset && read && !empty) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL popdata: unexpected pop got %0h expected none", dataOut);
      end else begin
        logic [WIDTH-1:0] e;
        e = expQ.pop_front();
        if (dataOut !== e) begin
          errors++;
          $display("FAIL popdata: got %0h expected %0h at %0t", dataOut, e, $time);
        end
      end
    end
  end

  task automatic popExpect(input logic [WIDTH-1:0] v);
    read = 1'b1;
    expQ.push_back(v);
    step();
    read = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    write  = 1'b0;
    read   = 1'b0;
    dataIn = '0;
    #2;
    // Reset state
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(almost_empty), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_dataOut", 32'(dataOut), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_udf", 32'(udf), 0);
    chk("rst_drops", 32'(drops), 0);
    step();
    reset = 1'b0;
    step();

    // Fill with four valid flits
    for (int i = 0; i < 4; i++) begin
      write  = 1'b1;
      dataIn = 16'(3 + 2 * i);
      step();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_dataOut", 32'(dataOut), 32'h3);
      chk("fill_aempty", 32'(almost_empty), 32'(i == 0));
      chk("fill_afull", 32'(almost_full), 32'(i == 2));
      chk("fill_full", 32'(full), 32'(i == 3));
    end

    // Overflow while full
    dataIn = 16'h000B;
    step();
    write = 1'b0;
    chk("ovf_count", 32'(count), 4);
    chk("ovf_flag", 32'(ovf), 32'(ERR));
    chk("ovf_drops", 32'(drops), ERR ? 32'd1 : 32'd0);
    popExpect(16'h0003);
    popExpect(16'h0005);
    popExpect(16'h0007);
    popExpect(16'h0009);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_dataOut", 32'(dataOut), 0);
    chk("drain_udf", 32'(udf), 0);

    // Empty bypass: push and read together while empty
    write  = 1'b1;
    read   = 1'b1;
    dataIn = 16'h0011;
    step();
    write = 1'b0;
    read  = 1'b0;
    chk("byp_udf", 32'(udf), 32'(ERR));
    chk("byp_count", 32'(count), 1);
    chk("byp_dataOut", 32'(dataOut), 32'h11);

    // Fill up, then push and pop together while full
    for (int i = 0; i < 3; i++) begin
      write  = 1'b1;
      dataIn = 16'(16'h15 + 2 * i);
      step();
    end
    chk("pt_prefull", 32'(full), 1);
    dataIn = 16'h0013;
    read   = 1'b1;
    expQ.push_back(16'h0011);
    step();
    write = 1'b0;
    read  = 1'b0;
    chk("pt_full", 32'(full), 1);
    chk("pt_count", 32'(count), 4);
    chk("pt_head", 32'(dataOut), 32'h15);
    chk("pt_drops", 32'(drops), ERR ? 32'd1 : 32'd0);

    // Invalid flit while full: neither stored nor counted as a drop
    write  = 1'b1;
    dataIn = 16'h0002;
    step();
    write = 1'b0;
    chk("inv_count", 32'(count), 4);
    chk("inv_drops", 32'(drops), ERR ? 32'd1 : 32'd0);
    popExpect(16'h0015);
    popExpect(16'h0017);
    popExpect(16'h0019);
    popExpect(16'h0013);
    chk("pt_empty", 32'(empty), 1);

    // Invalid flit while empty
    write  = 1'b1;
    dataIn = 16'h0002;
    step();
    write = 1'b0;
    chk("inv_empty", 32'(empty), 1);
    chk("inv_dataOut", 32'(dataOut), 0);

    // Alternating push/pop across pointer wrap
    for (int k = 0; k < 5; k++) begin
      write  = 1'b1;
      dataIn = 16'(16'h21 + 2 * k);
      step();
      write = 1'b0;
      chk("wrap_head", 32'(dataOut), 32'(16'h21 + 2 * k));
      chk("wrap_aempty", 32'(almost_empty), 1);
      popExpect(16'(16'h21 + 2 * k));
      chk("wrap_empty", 32'(empty), 1);
    end

    // Asynchronous reset with three flits held
    for (int i = 0; i < 3; i++) begin
      write  = 1'b1;
      dataIn = 16'(16'h31 + 2 * i);
      step();
    end
    write = 1'b0;
    chk("pre_rst_count", 32'(count), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_empty", 32'(empty), 1);
    chk("arst_dataOut", 32'(dataOut), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_ovf", 32'(ovf), 0);
    chk("arst_drops", 32'(drops), 0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_empty", 32'(empty), 1);
    chk("sb_leftover", 32'(expQ.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
